// File: rtl/chip8_sprite_blitter.sv
// CHIP-8/SCHIP sprite draw engine: XOR blits byte-packed sprites into VRAM with wrap or clip,
// clears the screen, and reports collisions through a busy/done handshake.
module chip8_sprite_blitter #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned HEIGHT = 32
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      start_in,
  input  logic                      clear_in,
  input  logic [11:0]               sprite_addr_in,
  input  logic [$clog2(WIDTH)-1:0]  x_in,
  input  logic [$clog2(HEIGHT)-1:0] y_in,
  input  logic [3:0]                height_in,
  input  logic                      wrap_in,
  input  logic                      wide_in,
  output logic                      busy_out,
  output logic                      done_out,
  output logic                      collision_out,
  output logic                      mem_valid_out,
  input  logic                      mem_ready_in,
  output logic                      mem_we_out,
  output logic                      mem_type_out,
  output logic [11:0]               mem_addr_out,
  output logic [7:0]                mem_wdata_out,
  input  logic                      mem_rvalid_in,
  input  logic [7:0]                mem_rdata_in
);

  localparam int unsigned XW     = $clog2(WIDTH);
  localparam int unsigned YW     = $clog2(HEIGHT);
  localparam int unsigned CW     = XW - 3;
  localparam int unsigned VAW    = CW + YW;
  localparam int unsigned RW     = YW + 5;
  localparam int unsigned NBYTES = WIDTH * HEIGHT / 8;

  typedef enum logic [2:0] {StIdle, StFetch, StRdV, StWrV, StClear, StDone} state_e;

  state_e state_q, state_d;

  logic [11:0]    base_q, base_d;
  logic [XW-1:0]  x_q, x_d;
  logic [YW-1:0]  y_q, y_d;
  logic [4:0]     rows_q, rows_d;
  logic           wrap_q, wrap_d;
  logic           wide_q, wide_d;
  logic [4:0]     row_q, row_d;
  logic [1:0]     cnt_q, cnt_d;
  logic [15:0]    spr_q, spr_d;
  logic [23:0]    old_q, old_d;
  logic           wait_q, wait_d;
  logic [VAW-1:0] clr_q, clr_d;
  logic           coll_q, coll_d;

  logic        mem_valid_q, mem_valid_d;
  logic        mem_we_q, mem_we_d;
  logic        mem_type_q, mem_type_d;
  logic [11:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [4:0]    rows_in;
  logic          issue_ok, acc, rd_done;
  logic [1:0]    nb_last, spr_last;
  logic [23:0]   win;
  logic [7:0]    win_byte, old_byte;
  logic [CW:0]   col_sum;
  logic [RW-1:0] row_sum, row_nxt;
  logic          row_end_j, row_last, clr_last;
  logic [11:0]   vram_addr, ram_addr;

  assign rows_in  = (wide_in && height_in == 4'd0) ? 5'd16 : {1'b0, height_in};
  assign issue_ok = !mem_valid_q && !wait_q;
  assign acc      = mem_valid_q && mem_ready_in;
  assign rd_done  = wait_q && mem_rvalid_in;
  assign nb_last  = wide_q ? 2'd2 : 2'd1;
  assign spr_last = {1'b0, wide_q};

  // Sprite row is top-aligned in a 24-bit window; byte j of the window is bits [23-8j -: 8].
  assign win = {spr_q[15:8], (wide_q ? spr_q[7:0] : 8'h00), 8'h00} >> x_q[2:0];

  always_comb begin
    win_byte = win[7:0];
    old_byte = old_q[7:0];
    case (cnt_q)
      2'd0: begin
        win_byte = win[23:16];
        old_byte = old_q[23:16];
      end
      2'd1: begin
        win_byte = win[15:8];
        old_byte = old_q[15:8];
      end
      default: ;
    endcase
  end

  // Clipped columns are always a tail of the row, so the first skipped byte ends the pass.
  assign col_sum   = {1'b0, x_q[XW-1:3]} + (CW+1)'(cnt_q);
  assign row_end_j = (cnt_q > nb_last) || (!wrap_q && col_sum[CW]);
  assign row_sum   = RW'(y_q) + RW'(row_q);
  assign row_nxt   = row_sum + RW'(1);
  assign row_last  = ((row_q + 5'd1) == rows_q) || (!wrap_q && row_nxt >= RW'(HEIGHT));
  assign clr_last  = (clr_q == VAW'(NBYTES - 1));
  assign vram_addr = 12'({row_sum[YW-1:0], col_sum[CW-1:0]});
  assign ram_addr  = base_q + (wide_q ? {6'd0, row_q, 1'b0} : {7'd0, row_q}) + {10'd0, cnt_q};

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (clear_in)      state_d = StClear;
        else if (start_in) state_d = (rows_in == 5'd0) ? StDone : StFetch;
      end
      StFetch: if (rd_done && cnt_q == spr_last) state_d = StRdV;
      StRdV:   if (issue_ok && row_end_j) state_d = StWrV;
      StWrV:   if (issue_ok && row_end_j) state_d = row_last ? StDone : StFetch;
      StClear: if (acc && clr_last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    base_d = base_q;
    x_d    = x_q;
    y_d    = y_q;
    rows_d = rows_q;
    wrap_d = wrap_q;
    wide_d = wide_q;
    row_d  = row_q;
    cnt_d  = cnt_q;
    spr_d  = spr_q;
    old_d  = old_q;
    wait_d = wait_q;
    clr_d  = clr_q;
    coll_d = coll_q;
    case (state_q)
      StIdle: begin
        if (clear_in) begin
          clr_d  = '0;
          coll_d = 1'b0;
        end else if (start_in) begin
          base_d = sprite_addr_in;
          x_d    = x_in;
          y_d    = y_in;
          rows_d = rows_in;
          wrap_d = wrap_in;
          wide_d = wide_in;
          row_d  = 5'd0;
          cnt_d  = 2'd0;
          coll_d = 1'b0;
        end
      end
      StFetch: begin
        if (acc) wait_d = 1'b1;
        if (rd_done) begin
          wait_d = 1'b0;
          if (cnt_q == 2'd0) spr_d[15:8] = mem_rdata_in;
          else               spr_d[7:0]  = mem_rdata_in;
          cnt_d = (cnt_q == spr_last) ? 2'd0 : cnt_q + 2'd1;
        end
      end
      StRdV: begin
        if (acc) wait_d = 1'b1;
        if (rd_done) begin
          wait_d = 1'b0;
          case (cnt_q)
            2'd0:    old_d[23:16] = mem_rdata_in;
            2'd1:    old_d[15:8]  = mem_rdata_in;
            default: old_d[7:0]   = mem_rdata_in;
          endcase
          cnt_d = cnt_q + 2'd1;
        end else if (issue_ok && row_end_j) begin
          cnt_d = 2'd0;
        end
      end
      StWrV: begin
        if (acc) begin
          coll_d = coll_q | (|(old_byte & win_byte));
          cnt_d  = cnt_q + 2'd1;
        end else if (issue_ok && row_end_j) begin
          cnt_d = 2'd0;
          if (!row_last) row_d = row_q + 5'd1;
        end
      end
      StClear: if (acc) clr_d = clr_q + VAW'(1);
      default: ;
    endcase
  end

  always_comb begin
    mem_valid_d = mem_valid_q && !mem_ready_in;
    mem_we_d    = mem_we_q;
    mem_type_d  = mem_type_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (issue_ok) begin
      case (state_q)
        StFetch: begin
          mem_valid_d = 1'b1;
          mem_we_d    = 1'b0;
          mem_type_d  = 1'b0;
          mem_addr_d  = ram_addr;
        end
        StRdV: if (!row_end_j) begin
          mem_valid_d = 1'b1;
          mem_we_d    = 1'b0;
          mem_type_d  = 1'b1;
          mem_addr_d  = vram_addr;
        end
        StWrV: if (!row_end_j) begin
          mem_valid_d = 1'b1;
          mem_we_d    = 1'b1;
          mem_type_d  = 1'b1;
          mem_addr_d  = vram_addr;
          mem_wdata_d = old_byte ^ win_byte;
        end
        StClear: begin
          mem_valid_d = 1'b1;
          mem_we_d    = 1'b1;
          mem_type_d  = 1'b1;
          mem_addr_d  = 12'(clr_q);
          mem_wdata_d = 8'h00;
        end
        default: ;
      endcase
    end
    busy_d = (state_d != StIdle) && (state_d != StDone);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      base_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      rows_q      <= '0;
      wrap_q      <= 1'b0;
      wide_q      <= 1'b0;
      row_q       <= '0;
      cnt_q       <= '0;
      spr_q       <= '0;
      old_q       <= '0;
      wait_q      <= 1'b0;
      clr_q       <= '0;
      coll_q      <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_type_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      base_q      <= base_d;
      x_q         <= x_d;
      y_q         <= y_d;
      rows_q      <= rows_d;
      wrap_q      <= wrap_d;
      wide_q      <= wide_d;
      row_q       <= row_d;
      cnt_q       <= cnt_d;
      spr_q       <= spr_d;
      old_q       <= old_d;
      wait_q      <= wait_d;
      clr_q       <= clr_d;
      coll_q      <= coll_d;
      mem_valid_q <= mem_valid_d;
      mem_we_q    <= mem_we_d;
      mem_type_q  <= mem_type_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy_out      = busy_q;
  assign done_out      = done_q;
  assign collision_out = coll_q;
  assign mem_valid_out = mem_valid_q;
  assign mem_we_out    = mem_we_q;
  assign mem_type_out  = mem_type_q;
  assign mem_addr_out  = mem_addr_q;
  assign mem_wdata_out = mem_wdata_q;

endmodule

// File: tb/tb_chip8_sprite_blitter.sv
// Scoreboard bench: a reference draw model queues the expected memory accesses, and a
// randomly stalling memory responder pops and compares them as the blitter issues requests.
module tb_chip8_sprite_blitter;

  typedef struct packed {
    logic        we;
    logic        typ;
    logic [11:0] addr;
    logic [7:0]  wdata;
  } acc_t;

  logic clk;
  logic rst, start, clear, wrap, wide, sel;
  logic [11:0] saddr;
  logic [6:0] x;
  logic [5:0] y;
  logic [3:0] h;
  logic m_ready, m_rvalid;
  logic [7:0] m_rdata;

  logic s_busy, s_done, s_coll, s_valid, s_we, s_type;
  logic b_busy, b_done, b_coll, b_valid, b_we, b_type;
  logic [11:0] s_addr, b_addr;
  logic [7:0] s_wdata, b_wdata;
  logic busy, done, coll, m_valid, m_we, m_type;
  logic [11:0] m_addr;
  logic [7:0] m_wdata;

  logic [7:0] ram [4096];
  logic [7:0] vram [1024];
  logic [7:0] shadow [1024];
  logic [7:0] shadow_save [1024];
  acc_t sb_q[$];

  int n_pass = 0, n_checks = 0;
  int n_ram_rd = 0, n_vram_rd = 0, n_vram_wr = 0, n_done = 0;
  logic stall_en = 1'b0;
  logic pend = 1'b0, stalled = 1'b0;
  int dly = 0;
  logic [7:0] pdata;
  acc_t held;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  chip8_sprite_blitter #(.WIDTH(64), .HEIGHT(32)) u_dut_s (
    .clk_in(clk), .rst_in(rst), .start_in(start & ~sel), .clear_in(clear & ~sel),
    .sprite_addr_in(saddr), .x_in(x[5:0]), .y_in(y[4:0]), .height_in(h), .wrap_in(wrap),
    .wide_in(wide), .busy_out(s_busy), .done_out(s_done), .collision_out(s_coll),
    .mem_valid_out(s_valid), .mem_ready_in(m_ready & ~sel), .mem_we_out(s_we),
    .mem_type_out(s_type), .mem_addr_out(s_addr), .mem_wdata_out(s_wdata),
    .mem_rvalid_in(m_rvalid & ~sel), .mem_rdata_in(m_rdata)
  );

  chip8_sprite_blitter #(.WIDTH(128), .HEIGHT(64)) u_dut_b (
    .clk_in(clk), .rst_in(rst), .start_in(start & sel), .clear_in(clear & sel),
    .sprite_addr_in(saddr), .x_in(x), .y_in(y), .height_in(h), .wrap_in(wrap),
    .wide_in(wide), .busy_out(b_busy), .done_out(b_done), .collision_out(b_coll),
    .mem_valid_out(b_valid), .mem_ready_in(m_ready & sel), .mem_we_out(b_we),
    .mem_type_out(b_type), .mem_addr_out(b_addr), .mem_wdata_out(b_wdata),
    .mem_rvalid_in(m_rvalid & sel), .mem_rdata_in(m_rdata)
  );

  assign busy    = sel ? b_busy  : s_busy;
  assign done    = sel ? b_done  : s_done;
  assign coll    = sel ? b_coll  : s_coll;
  assign m_valid = sel ? b_valid : s_valid;
  assign m_we    = sel ? b_we    : s_we;
  assign m_type  = sel ? b_type  : s_type;
  assign m_addr  = sel ? b_addr  : s_addr;
  assign m_wdata = sel ? b_wdata : s_wdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic serve(input acc_t cur);
    acc_t e, c;
    c = cur;
    if (!c.we) c.wdata = 8'h00;
    if (sb_q.size() == 0) begin
      check("unexpected_access", 32'(c), 32'hFFFF_FFFF);
    end else begin
      e = sb_q.pop_front();
      check("access", 32'(c), 32'(e));
    end
    if (cur.we) begin
      if (cur.typ) vram[cur.addr[9:0]] = cur.wdata;
      n_vram_wr++;
    end else begin
      pend  = 1'b1;
      dly   = $urandom_range(0, 2);
      pdata = cur.typ ? vram[cur.addr[9:0]] : ram[cur.addr];
      if (cur.typ) n_vram_rd++;
      else         n_ram_rd++;
    end
  endtask

  // Memory responder: decides ready for the coming edge and serves the request it will accept.
  always @(negedge clk) begin
    acc_t cur;
    m_rvalid = 1'b0;
    if (rst) begin
      pend    = 1'b0;
      stalled = 1'b0;
      m_ready = 1'b0;
    end else begin
      if (pend) begin
        if (dly == 0) begin
          m_rvalid = 1'b1;
          m_rdata  = pdata;
          pend     = 1'b0;
        end else dly--;
      end
      if (m_valid) begin
        cur = '{we: m_we, typ: m_type, addr: m_addr, wdata: m_wdata};
        if (stalled) check("stable_while_stalled", 32'(cur), 32'(held));
        else         check("one_outstanding", 32'(pend), 32'd0);
        if (!stall_en || $urandom_range(0, 2) != 0) begin
          m_ready = 1'b1;
          stalled = 1'b0;
          serve(cur);
        end else begin
          m_ready = 1'b0;
          stalled = 1'b1;
          held    = cur;
        end
      end else begin
        m_ready = 1'b0;
      end
    end
  end

  always @(negedge clk) if (!rst && done) n_done++;

  task automatic model_draw(input int w, input int hh, input logic [11:0] a, input int xx,
                            input int yy, input int hgt, input bit wr, input bit wd,
                            output bit exp_coll);
    int rows, nb, bpr, row, c;
    logic [7:0] s [2];
    logic [23:0] wv;
    logic [7:0] wj [3];
    int va [3];
    bit keep [3];
    logic [11:0] ra;
    logic [7:0] nv;
    exp_coll = 1'b0;
    rows = (wd && hgt == 0) ? 16 : hgt;
    nb   = wd ? 2 : 1;
    bpr  = w / 8;
    s[1] = 8'h00;
    for (int r = 0; r < rows; r++) begin
      row = yy + r;
      if (row >= hh) begin
        if (wr) row -= hh;
        else break;
      end
      for (int b = 0; b < nb; b++) begin
        ra = a + 12'(r * nb + b);
        s[b] = ram[ra];
        sb_q.push_back('{we: 1'b0, typ: 1'b0, addr: ra, wdata: 8'h00});
      end
      if (wd) wv = {s[0], s[1], 8'h00} >> (xx % 8);
      else    wv = {8'h00, s[0], 8'h00} >> (xx % 8);
      for (int j = 0; j <= nb; j++) begin
        wj[j]   = wv[8 * (nb - j) +: 8];
        c       = xx / 8 + j;
        keep[j] = 1'b1;
        if (c >= bpr) begin
          if (wr) c -= bpr;
          else keep[j] = 1'b0;
        end
        va[j] = row * bpr + c;
      end
      for (int j = 0; j <= nb; j++)
        if (keep[j]) sb_q.push_back('{we: 1'b0, typ: 1'b1, addr: 12'(va[j]), wdata: 8'h00});
      for (int j = 0; j <= nb; j++) begin
        if (keep[j]) begin
          if ((shadow[va[j]] & wj[j]) != 8'h00) exp_coll = 1'b1;
          nv = shadow[va[j]] ^ wj[j];
          shadow[va[j]] = nv;
          sb_q.push_back('{we: 1'b1, typ: 1'b1, addr: 12'(va[j]), wdata: nv});
        end
      end
    end
  endtask

  task automatic wait_done(input string tag);
    int k;
    for (k = 0; k < 20000; k++) begin
      if (done) break;
      @(negedge clk);
    end
    if (k == 20000) check({tag, "_timeout"}, 32'd0, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_draw(input string tag, input bit bsel, input logic [11:0] a, input int xx,
                         input int yy, input int hgt, input bit wr, input bit wd,
                         input bit poke);
    bit exp_coll;
    int d0;
    @(negedge clk);
    sel = bsel; saddr = a; x = 7'(xx); y = 6'(yy); h = 4'(hgt); wrap = wr; wide = wd;
    start = 1'b1;
    model_draw(bsel ? 128 : 64, bsel ? 64 : 32, a, xx, yy, hgt, wr, wd, exp_coll);
    d0 = n_done;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'((wd || hgt != 0) ? 1 : 0));
    saddr = 12'($urandom); x = 7'($urandom); y = 6'($urandom); h = 4'($urandom);
    wrap = 1'($urandom); wide = 1'($urandom);
    if (poke) begin
      repeat (3) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done(tag);
    check({tag, "_coll"}, 32'(coll), 32'(exp_coll));
    check({tag, "_done_pulses"}, 32'(n_done - d0), 32'd1);
    check({tag, "_queue_empty"}, 32'(sb_q.size()), 32'd0);
  endtask

  task automatic do_clear(input string tag, input bit bsel, input int nbytes);
    int d0, w0;
    @(negedge clk);
    sel = bsel;
    clear = 1'b1;
    start = 1'b1;
    for (int i = 0; i < nbytes; i++) begin
      shadow[i] = 8'h00;
      sb_q.push_back('{we: 1'b1, typ: 1'b1, addr: 12'(i), wdata: 8'h00});
    end
    d0 = n_done;
    w0 = n_vram_wr;
    @(negedge clk);
    clear = 1'b0;
    start = 1'b0;
    wait_done(tag);
    check({tag, "_coll"}, 32'(coll), 32'd0);
    check({tag, "_done_pulses"}, 32'(n_done - d0), 32'd1);
    check({tag, "_writes"}, 32'(n_vram_wr - w0), 32'(nbytes));
    check({tag, "_queue_empty"}, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    int r0, v0, w0, k;
    rst = 1'b1; start = 1'b0; clear = 1'b0; wrap = 1'b0; wide = 1'b0; sel = 1'b0;
    saddr = '0; x = '0; y = '0; h = '0; m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    for (int i = 0; i < 4096; i++) ram[i] = 8'($urandom);
    for (int i = 0; i < 1024; i++) begin
      vram[i] = 8'h00;
      shadow[i] = 8'h00;
    end
    ram[12'h200] = 8'hF0;
    ram[12'h300] = 8'hFF;
    ram[12'h301] = 8'hFF;
    repeat (3) @(negedge clk);
    check("reset_outputs_small", {28'd0, s_busy, s_done, s_coll, s_valid}, 32'd0);
    check("reset_outputs_big",   {28'd0, b_busy, b_done, b_coll, b_valid}, 32'd0);
    rst = 1'b0;

    do_draw("first_draw", 1'b0, 12'h200, 4, 0, 1, 1'b0, 1'b0, 1'b0);
    check("first_vram0", 32'(vram[0]), 32'h0F);
    check("first_vram1", 32'(vram[1]), 32'h00);
    check("first_coll",  32'(coll), 32'd0);
    do_draw("redraw", 1'b0, 12'h200, 4, 0, 1, 1'b0, 1'b0, 1'b1);
    check("redraw_vram0", 32'(vram[0]), 32'h00);
    check("redraw_coll",  32'(coll), 32'd1);

    do_clear("clear_a", 1'b0, 256);
    do_draw("wrap_draw", 1'b0, 12'h300, 60, 31, 2, 1'b1, 1'b0, 1'b0);
    check("wrap_vram255", 32'(vram[255]), 32'h0F);
    check("wrap_vram248", 32'(vram[248]), 32'hF0);
    check("wrap_vram7",   32'(vram[7]),   32'h0F);
    check("wrap_vram0",   32'(vram[0]),   32'hF0);

    do_clear("clear_b", 1'b0, 256);
    r0 = n_ram_rd;
    v0 = n_vram_rd + n_vram_wr;
    do_draw("clip_draw", 1'b0, 12'h300, 60, 31, 2, 1'b0, 1'b0, 1'b0);
    check("clip_vram255",  32'(vram[255]), 32'h0F);
    check("clip_ram_reads", 32'(n_ram_rd - r0), 32'd1);
    check("clip_vram_accesses", 32'(n_vram_rd + n_vram_wr - v0), 32'd2);

    stall_en = 1'b1;
    do_clear("clear_stall", 1'b0, 256);
    for (int i = 0; i < 8; i++)
      do_draw("rand_small", 1'b0, 12'($urandom), $urandom_range(0, 63), $urandom_range(0, 31),
              $urandom_range(0, 15), 1'($urandom), 1'($urandom), 1'b0);

    r0 = n_ram_rd + n_vram_rd + n_vram_wr;
    do_draw("zero_rows", 1'b0, 12'h200, 8, 8, 0, 1'b1, 1'b0, 1'b0);
    check("zero_rows_no_access", 32'(n_ram_rd + n_vram_rd + n_vram_wr - r0), 32'd0);

    do_clear("clear_big", 1'b1, 1024);
    r0 = n_ram_rd; v0 = n_vram_rd; w0 = n_vram_wr;
    do_draw("wide16", 1'b1, 12'h400, 0, 0, 0, 1'b1, 1'b1, 1'b0);
    check("wide16_ram_reads",  32'(n_ram_rd - r0),  32'd32);
    check("wide16_vram_reads", 32'(n_vram_rd - v0), 32'd48);
    check("wide16_writes",     32'(n_vram_wr - w0), 32'd48);
    for (int i = 0; i < 4; i++)
      do_draw("rand_big", 1'b1, 12'($urandom), $urandom_range(0, 127), $urandom_range(0, 63),
              $urandom_range(0, 15), 1'($urandom), 1'($urandom), 1'b0);

    // Abort during the first VRAM read; no write may have happened yet.
    shadow_save = shadow;
    w0 = n_vram_wr;
    do_clear("clear_pre_rst", 1'b0, 256);
    shadow_save = shadow;
    w0 = n_vram_wr;
    begin
      bit dummy;
      @(negedge clk);
      sel = 1'b0; saddr = 12'h200; x = 7'd12; y = 6'd3; h = 4'd3; wrap = 1'b1; wide = 1'b0;
      start = 1'b1;
      model_draw(64, 32, 12'h200, 12, 3, 3, 1'b1, 1'b0, dummy);
      @(negedge clk);
      start = 1'b0;
      for (k = 0; k < 200; k++) begin
        if (m_valid && m_type && !m_we) break;
        @(negedge clk);
      end
      check("rst_reach_rdv", 32'(k < 200), 32'd1);
      #1 rst = 1'b1;
      #1;
      check("rst_valid_drop", 32'(m_valid), 32'd0);
      check("rst_busy_drop",  32'(busy), 32'd0);
      sb_q.delete();
      shadow = shadow_save;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("rst_no_writes", 32'(n_vram_wr - w0), 32'd0);
      check("rst_coll_done", {30'd0, coll, done}, 32'd0);
    end
    do_draw("post_rst", 1'b0, 12'h200, 20, 10, 5, 1'b0, 1'b0, 1'b1);
    do_draw("post_rst_wide", 1'b0, 12'h210, 57, 28, 9, 1'b0, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
